// File: rtl/mem_bus_unit.sv
// mem_bus_unit: MAR/MDR bus interface to a wait-stated RAM with memory-mapped I/O ports
module mem_bus_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1,
  parameter int NUM_PORTS   = 2,
  parameter int IO_BASE     = 2**ADDR_W - NUM_PORTS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           bus,
  input  logic                        mar_in,
  input  logic                        mdr_in,
  input  logic                        rd_req,
  input  logic                        wr_req,
  output logic [DATA_W-1:0]           mdr_data,
  output logic                        busy,
  output logic                        ack,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic                        ram_we,
  output logic                        ram_re,
  input  logic [NUM_PORTS*DATA_W-1:0] inport_data,
  output logic [NUM_PORTS*DATA_W-1:0] outport_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [2:0]        WS        = 3'(WAIT_STATES);
  state_t                      state, state_nx;
  logic [ADDR_W-1:0]           mar, pidx;
  logic [DATA_W-1:0]           mdr, io_rdata;
  logic [2:0]                  wcnt;
  logic                        rd_op, is_io, start, last;
  logic [NUM_PORTS*DATA_W-1:0] inp, outp;
  always_comb begin
    is_io    = mar >= IO_BASE_A;
    pidx     = mar - IO_BASE_A;
    start    = state == IDLE && (rd_req || wr_req);
    last     = state == ACCESS && (is_io || wcnt == 3'd0);
    state_nx = start ? ACCESS : last ? DONE : state == DONE ? IDLE : state;
    io_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (pidx == ADDR_W'(i)) io_rdata = inp[i*DATA_W +: DATA_W];
    busy      = state != IDLE;
    ack       = state == DONE;
    ram_re    = state == ACCESS && !is_io && rd_op;
    ram_we    = state == ACCESS && !is_io && !rd_op;
    ram_addr  = mar;
    ram_wdata = mdr;
    mdr_data  = mdr;
    outport_data = outp;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // a simultaneous rd_req/wr_req resolves to a read because rd_op takes rd_req
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mar   <= '0;
      mdr   <= '0;
      wcnt  <= '0;
      rd_op <= 1'b0;
      inp   <= '0;
      outp  <= '0;
    end else begin
      inp <= inport_data;
      if (state == IDLE && mar_in) mar <= bus[ADDR_W-1:0];
      if (state == IDLE && mdr_in) mdr <= bus;
      if (start) begin
        rd_op <= rd_req;
        wcnt  <= WS;
      end else if (state == ACCESS && wcnt != 3'd0) wcnt <= wcnt - 3'd1;
      if (last && rd_op) mdr <= is_io ? io_rdata : ram_rdata;
      if (last && !rd_op && is_io)
        for (int i = 0; i < NUM_PORTS; i++)
          if (pidx == ADDR_W'(i)) outp[i*DATA_W +: DATA_W] <= mdr;
    end
endmodule

// File: doc/mem_bus_unit.md
MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of bus, MDR, RAM data and each I/O port.
REQ-002 Parameter ADDR_W, default 9, width of MAR and RAM address.
REQ-003 Parameter WAIT_STATES, default 1, extra RAM cycles per access; legal range 0-7.
REQ-004 Parameter NUM_PORTS, default 2, memory-mapped I/O port pairs; legal range 1-8.
REQ-005 Parameter IO_BASE, default 2**ADDR_W-NUM_PORTS, first I/O-mapped address.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 bus  in  DATA_W  shared datapath bus.
REQ-010 mar_in  in  1  load MAR from bus[ADDR_W-1:0].
REQ-011 mdr_in  in  1  load MDR from bus.
REQ-012 rd_req  in  1  start read from MAR address.
REQ-013 wr_req  in  1  start write of MDR to MAR address.
REQ-014 mdr_data  out  DATA_W  MDR contents.
REQ-015 busy  out  1  access in progress.
REQ-016 ack  out  1  one-cycle completion pulse.
REQ-017 ram_addr  out  ADDR_W  RAM address (equals MAR).
REQ-018 ram_wdata  out  DATA_W  RAM write data (equals MDR).
REQ-019 ram_rdata  in  DATA_W  RAM read data.
REQ-020 ram_we / ram_re  out  1 each  RAM write/read strobes.
REQ-021 inport_data  in  NUM_PORTS*DATA_W  external inputs, port i at [i*DATA_W +: DATA_W].
REQ-022 outport_data  out  NUM_PORTS*DATA_W  output port registers, same packing.

Function
REQ-023 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on rd_req|wr_req; ACCESS->DONE when wait counter expires; DONE->IDLE unconditionally.
REQ-024 rd_req and wr_req both high in IDLE SHALL start a read; the write is dropped.
REQ-025 Requests, mar_in and mdr_in while busy SHALL be ignored, not queued.
REQ-026 busy SHALL be high in ACCESS and DONE; ack SHALL be high only in DONE.
REQ-027 RAM access (MAR < IO_BASE): ACCESS lasts WAIT_STATES+1 cycles; ram_re (read) or ram_we (write) high for all of them, low otherwise.
REQ-028 RAM read: MDR captures ram_rdata on the final ACCESS edge; value visible in DONE.
REQ-029 Request sampled at edge 0: ack high in cycle WAIT_STATES+2 for RAM, cycle 2 for I/O.
REQ-030 I/O access (MAR >= IO_BASE): ACCESS lasts 1 cycle regardless of WAIT_STATES; ram_re/ram_we stay low.
REQ-031 Port index = MAR-IO_BASE; I/O write loads MDR into outport register at index; I/O read loads inport register at index into MDR.
REQ-032 Inport registers SHALL sample inport_data every cycle (one-stage capture).
REQ-033 MAR/MDR loads from bus take effect at the clock edge in which mar_in/mdr_in are high in IDLE.
REQ-034 Wait counter counts down from WAIT_STATES, no wrap; loaded on IDLE->ACCESS.

Reset
REQ-035 rst low SHALL immediately force state IDLE, clear MAR, MDR, wait counter, inport and outport registers, and drive busy, ack, ram_we, ram_re to 0.
REQ-036 rst asserted mid-access SHALL abort it: no ack, no MDR or outport update.

Verification
REQ-037 WAIT_STATES=1: load MAR=0x012, MDR=0xDEADBEEF, wr_req -> ram_we high cycles 1-2, ram_addr=0x012, ram_wdata=0xDEADBEEF, ack cycle 3.
REQ-038 WAIT_STATES=1, ram_rdata=0xDEADBEEF, rd_req at MAR=0x012 -> ram_re cycles 1-2, mdr_data=0xDEADBEEF and ack in cycle 3.
REQ-039 WAIT_STATES=0: read -> ram_re cycle 1 only, ack cycle 2.
REQ-040 ADDR_W=9, NUM_PORTS=2: MAR=511, MDR=0x55, wr_req -> outport_data[63:32]=0x55, ram_we never high, ack cycle 2; inport_data[31:0]=0xA5A5, read at MAR=510 -> mdr_data=0xA5A5.
REQ-041 During busy: mar_in with bus=0x1FF and second rd_req -> MAR unchanged, exactly one ack.
REQ-042 rst low in cycle 1 of a RAM write -> ram_we 0 immediately, no ack, busy 0, MDR=0 after release.
